// File: rtl/ex_mdu.sv
// rtl/ex_mdu.sv - execute stage: logic/shift/arith/move results, HI/LO with multiply and optional divider
// Optional multi-cycle divider is compiled in when EX_MDU_DIV_EN is defined.
module ex_mdu #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        aluop_i,
    input  logic [2:0]        alusel_i,
    input  logic [DATA_W-1:0] reg1_i,
    input  logic [DATA_W-1:0] reg2_i,
    input  logic [REG_AW-1:0] wd_i,
    input  logic              wreg_i,
    input  logic              flush_i,
    output logic [REG_AW-1:0] wd_o,
    output logic              wreg_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              stallreq_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);
    localparam logic [7:0] EXE_AND_OP   = 8'b0010_0100;
    localparam logic [7:0] EXE_OR_OP    = 8'b0010_0101;
    localparam logic [7:0] EXE_XOR_OP   = 8'b0010_0110;
    localparam logic [7:0] EXE_NOR_OP   = 8'b0010_0111;
    localparam logic [7:0] EXE_SLL_OP   = 8'b0111_1100;
    localparam logic [7:0] EXE_SRL_OP   = 8'b0000_0010;
    localparam logic [7:0] EXE_SRA_OP   = 8'b0000_0011;
    localparam logic [7:0] EXE_SLT_OP   = 8'b0010_1010;
    localparam logic [7:0] EXE_SLTU_OP  = 8'b0010_1011;
    localparam logic [7:0] EXE_ADDU_OP  = 8'b0010_0001;
    localparam logic [7:0] EXE_SUBU_OP  = 8'b0010_0011;
    localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
    localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
    localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;
    localparam logic [7:0] EXE_MFHI_OP  = 8'b0001_0000;
    localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
    localparam logic [7:0] EXE_MFLO_OP  = 8'b0001_0010;
    localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;

    localparam logic [2:0] EXE_RES_LOGIC      = 3'b001;
    localparam logic [2:0] EXE_RES_SHIFT      = 3'b010;
    localparam logic [2:0] EXE_RES_MOVE       = 3'b011;
    localparam logic [2:0] EXE_RES_ARITHMETIC = 3'b100;

    localparam int SH_W = $clog2(DATA_W);

    logic [DATA_W-1:0]   hi_q, lo_q;
    logic [SH_W-1:0]     shamt;
    logic [2*DATA_W-1:0] prod_s, prod_u;
    logic                idle;
    logic                div_wr;
    logic [DATA_W-1:0]   div_hi, div_lo;

    assign wd_o   = wd_i;
    assign wreg_o = wreg_i;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;
    assign shamt  = reg1_i[SH_W-1:0];

    // Sign- or zero-extend to full product width so the low 2*DATA_W bits are exact.
    assign prod_s = {{DATA_W{reg1_i[DATA_W-1]}}, reg1_i} * {{DATA_W{reg2_i[DATA_W-1]}}, reg2_i};
    assign prod_u = {{DATA_W{1'b0}}, reg1_i} * {{DATA_W{1'b0}}, reg2_i};

    always_comb begin
        wdata_o = '0;
        case (alusel_i)
            EXE_RES_LOGIC: begin
                case (aluop_i)
                    EXE_AND_OP: wdata_o = reg1_i & reg2_i;
                    EXE_OR_OP:  wdata_o = reg1_i | reg2_i;
                    EXE_XOR_OP: wdata_o = reg1_i ^ reg2_i;
                    EXE_NOR_OP: wdata_o = ~(reg1_i | reg2_i);
                    default:    wdata_o = '0;
                endcase
            end
            EXE_RES_SHIFT: begin
                case (aluop_i)
                    EXE_SLL_OP: wdata_o = reg2_i << shamt;
                    EXE_SRL_OP: wdata_o = reg2_i >> shamt;
                    EXE_SRA_OP: wdata_o = $unsigned($signed(reg2_i) >>> shamt);
                    default:    wdata_o = '0;
                endcase
            end
            EXE_RES_ARITHMETIC: begin
                case (aluop_i)
                    EXE_ADDU_OP: wdata_o = reg1_i + reg2_i;
                    EXE_SUBU_OP: wdata_o = reg1_i - reg2_i;
                    EXE_SLT_OP:  wdata_o = {{(DATA_W-1){1'b0}}, $signed(reg1_i) < $signed(reg2_i)};
                    EXE_SLTU_OP: wdata_o = {{(DATA_W-1){1'b0}}, reg1_i < reg2_i};
                    default:     wdata_o = '0;
                endcase
            end
            EXE_RES_MOVE: begin
                case (aluop_i)
                    EXE_MFHI_OP: wdata_o = hi_q;
                    EXE_MFLO_OP: wdata_o = lo_q;
                    default:     wdata_o = '0;
                endcase
            end
            default: wdata_o = '0;
        endcase
    end

`ifdef EX_MDU_DIV_EN
    typedef enum logic [1:0] {S_IDLE, S_BYZERO, S_RUN, S_DONE} state_t;

    localparam int CNT_W = $clog2(DATA_W);

    state_t            state;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] divd;   // dividend shifting out, quotient shifting in
    logic [DATA_W-1:0] divs;
    logic [DATA_W-1:0] part;   // partial remainder
    logic              neg_q, neg_r;
    logic              is_div, is_sgn;
    logic [DATA_W-1:0] mag_a, mag_b;
    logic [DATA_W:0]   trial;
    logic              ge;

    assign is_div = (aluop_i == EXE_DIV_OP) || (aluop_i == EXE_DIVU_OP);
    assign is_sgn = (aluop_i == EXE_DIV_OP);
    assign mag_a  = (is_sgn && reg1_i[DATA_W-1]) ? -reg1_i : reg1_i;
    assign mag_b  = (is_sgn && reg2_i[DATA_W-1]) ? -reg2_i : reg2_i;
    assign trial  = {part, divd[DATA_W-1]} - {1'b0, divs};
    assign ge     = ~trial[DATA_W];

    assign idle       = (state == S_IDLE);
    assign stallreq_o = (idle && is_div) || (state == S_BYZERO) || (state == S_RUN);
    assign div_wr     = (state == S_DONE) && !flush_i;
    assign div_lo     = neg_q ? -divd : divd;
    assign div_hi     = neg_r ? -part : part;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            count <= '0;
            divd  <= '0;
            divs  <= '0;
            part  <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (flush_i) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (is_div) begin
                        divs <= mag_b;
                        if (reg2_i == '0) begin
                            part  <= reg1_i;
                            divd  <= '1;
                            neg_q <= 1'b0;
                            neg_r <= 1'b0;
                            state <= S_BYZERO;
                        end else begin
                            part  <= '0;
                            divd  <= mag_a;
                            count <= '0;
                            neg_q <= is_sgn && (reg1_i[DATA_W-1] ^ reg2_i[DATA_W-1]);
                            neg_r <= is_sgn && reg1_i[DATA_W-1];
                            state <= S_RUN;
                        end
                    end
                end
                S_BYZERO: state <= S_DONE;
                S_RUN: begin
                    part  <= ge ? trial[DATA_W-1:0] : {part[DATA_W-2:0], divd[DATA_W-1]};
                    divd  <= {divd[DATA_W-2:0], ge};
                    count <= count + CNT_W'(1);
                    if (count == CNT_W'(DATA_W-1))
                        state <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
`else
    logic unused_div;

    assign unused_div = flush_i;
    assign idle       = 1'b1;
    assign stallreq_o = 1'b0;
    assign div_wr     = 1'b0;
    assign div_hi     = '0;
    assign div_lo     = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (div_wr) begin
            hi_q <= div_hi;
            lo_q <= div_lo;
        end else if (idle) begin
            case (aluop_i)
                EXE_MULT_OP:  {hi_q, lo_q} <= prod_s;
                EXE_MULTU_OP: {hi_q, lo_q} <= prod_u;
                EXE_MTHI_OP:  hi_q <= reg1_i;
                EXE_MTLO_OP:  lo_q <= reg1_i;
                default: ;
            endcase
        end
    end
endmodule

// File: doc/ex_mdu.md
EX_MDU -- requirements
Module: ex_mdu

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning operand/result width; legal values 16, 32 or 64.
REQ-002 SHALL have parameter REG_AW, default 5, meaning destination register address width.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  reset: synchronous, active-high.
REQ-005 SHALL have ports aluop_i input 8 and alusel_i input 3, meaning operation subtype and class (`EXE_*_OP` / `EXE_RES_*` codes).
REQ-006 SHALL have ports reg1_i and reg2_i, each input DATA_W, meaning source operands.
REQ-007 SHALL have ports wd_i input REG_AW and wreg_i input 1, meaning destination address and write enable from decode.
REQ-008 SHALL have port flush_i  input  1  meaning abort of any in-flight divide.
REQ-009 SHALL have ports wd_o output REG_AW, wreg_o output 1 and wdata_o output DATA_W, meaning writeback destination, enable and data.
REQ-010 SHALL have port stallreq_o  output  1  meaning hold-pipeline request.
REQ-011 SHALL have ports hi_o and lo_o, each output DATA_W, meaning current HI/LO register contents.

Function
REQ-012 Outputs wd_o and wreg_o SHALL be combinational copies of wd_i and wreg_i.
REQ-013 wdata_o SHALL be combinational, selected by alusel_i:
- LOGIC: AND/OR/XOR/NOR.
- SHIFT: SLL/SRL/SRA by reg1_i[log2(DATA_W)-1:0] applied to reg2_i.
- ARITH: ADDU/SUBU modulo 2^DATA_W, plus SLT (signed) and SLTU (unsigned) giving 1 or 0.
- MOVE: MFHI gives HI, MFLO gives LO.
- Any other alusel_i: 0.
REQ-014 Unlisted aluop_i within a class SHALL yield wdata_o=0.
REQ-015 MULT and MULTU SHALL compute the signed or unsigned 2*DATA_W product in one cycle and write {HI,LO} at the next edge.
REQ-016 MTHI and MTLO SHALL write reg1_i to HI or LO respectively at the next edge.
REQ-017 HI and LO SHALL be registers; a value written at edge N SHALL be visible on MFHI, MFLO, hi_o and lo_o from cycle N+1 onward, with no bypass.
REQ-018 The divider FSM states SHALL be IDLE, BYZERO, RUN and DONE.
REQ-019 In IDLE with aluop_i=DIV or DIVU, the FSM SHALL latch the operands and go to BYZERO if reg2_i==0, otherwise go to RUN with count=0.
REQ-020 RUN SHALL perform one restoring-division step per cycle on operand magnitudes, and SHALL go to DONE after DATA_W cycles.
REQ-021 BYZERO SHALL go to DONE after one cycle with quotient=all ones and remainder=dividend.
REQ-022 At the edge leaving DONE, HI SHALL receive the remainder and LO the quotient, and the FSM SHALL go to IDLE unconditionally.
REQ-023 For signed DIV, the quotient SHALL be negated when the operand signs differ, and the remainder SHALL take the dividend's sign.
REQ-024 stallreq_o SHALL be 1 while a divide op is presented in IDLE, in BYZERO and in RUN, and SHALL be 0 in DONE; a non-zero divide therefore stalls DATA_W+1 cycles.
REQ-025 flush_i=1 SHALL force the FSM to IDLE at the next edge with no HI/LO write, and SHALL override divide start.
REQ-026 MULT, MTHI and MTLO presented while the FSM is not IDLE SHALL be ignored.

Reset
REQ-027 With rst=1 at an edge, HI, LO, the FSM state, the count and the latched operands SHALL clear (state IDLE), and the cycle after reset SHALL show stallreq_o=0, hi_o=0 and lo_o=0.
REQ-028 Reset during RUN SHALL abort the divide without any HI/LO write.

Configuration
REQ-029 Macro EX_MDU_DIV_EN defined SHALL include the divider FSM (REQ-018 to REQ-026 divider behaviour).
REQ-030 Without EX_MDU_DIV_EN, DIV and DIVU SHALL be no-ops, stallreq_o SHALL be tied to 0, and all other functions SHALL be unchanged.

Verification (DATA_W=32)
REQ-031 OR 0x0F0F0000 with 0x000000FF, alusel LOGIC -> wdata_o=0x0F0F00FF in the same cycle.
REQ-032 MULT 0xFFFFFFFE by 3, then MFHI and MFLO -> HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-033 DIV -7 by 2 held while stalled -> stallreq_o high for 33 cycles, then LO=0xFFFFFFFD and HI=0xFFFFFFFF.
REQ-034 DIVU 5 by 0 -> stall for 2 cycles, then LO=0xFFFFFFFF and HI=5.
REQ-035 DIVU 100 by 7 with flush_i pulsed at RUN cycle 10 -> state IDLE, stallreq_o=0, HI/LO unchanged.
REQ-036 rst asserted at RUN cycle 5 -> next cycle stallreq_o=0 and hi_o=lo_o=0.
